ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that sits directly in front of, and behind, the team's simple dual-port RAM (wclk = rclk = clk). It generates the RAM write and read addresses and enables, and captures the RAM's 1-cycle-latency read data into a registered first-word-fall-through output. Game logic uses it to queue guess and feedback words between modules.

Parameters:
WIDTH, 8, word width; must match the RAM SIZE.
DEPTH, 8, total FIFO capacity in words; power of two, >= 2; must match the RAM DEPTH.

Ports:
clk  input  1  system clock; also drives the RAM wclk and rclk.
rst_n  input  1  asynchronous, active-low reset.
din  input  WIDTH  data to enqueue.
wput  input  1  enqueue request.
full  output  1  high when count == DEPTH; a wput is ignored while full is high.
overflow  output  1  1-cycle pulse when wput arrives while full.
dout  output  WIDTH  head word; valid while empty is low.
rget  input  1  dequeue request.
empty  output  1  high when no word is in the output register.
underflow  output  1  1-cycle pulse when rget arrives while empty.
count  output  $clog2(DEPTH)+1  words held (ram_cnt + fetch_pending + out_valid).
ram_waddr  output  $clog2(DEPTH)  RAM write address (= wr_ptr).
ram_wdata  output  WIDTH  RAM write data (= din, combinational).
ram_wen  output  1  RAM write enable (= push, combinational).
ram_raddr  output  $clog2(DEPTH)  RAM read address (= rd_ptr).
ram_rdata  input  WIDTH  RAM read_data; holds mem[raddr] sampled at the previous edge.

Behaviour:
- Async reset (rst_n = 0) clears wr_ptr, rd_ptr, ram_cnt, fetch_pending, out_valid and dout to 0, and clears both pulses. After reset: empty = 1, full = 0, count = 0. Reset mid-operation discards all queued data, and RAM contents are ignored afterwards.
- Definitions:
  - push = wput & ~full.
  - pop = rget & out_valid.
  - occ = out_valid - pop + fetch_pending (0..1).
  - fetch = (ram_cnt != 0) & (occ == 0) & ~fetch_pending.
- Push: RAM is written at wr_ptr; wr_ptr <= wr_ptr + 1, wrapping mod DEPTH.
- Fetch: rd_ptr <= rd_ptr + 1 (wrapping mod DEPTH). fetch_pending <= 1. The RAM samples ram_raddr = old rd_ptr on this edge.
- Landing: in the cycle with fetch_pending = 1, dout <= ram_rdata and out_valid <= 1 at the next edge. fetch_pending <= fetch.
- Pop: out_valid <= 0 unless a landing occurs on the same edge. dout holds its last value when not loaded.
- ram_cnt: next = ram_cnt + push - fetch. Simultaneous push and fetch leaves it unchanged.
- Status flags:
  - empty = ~out_valid.
  - full = (count == DEPTH).
  - Both are combinational from registers only, with no input-to-output paths except ram_wen and ram_wdata.
- Full blocks writes even when rget is high in the same cycle. There is no write-through.
- Collision freedom: fetch requires ram_cnt > 0 and push requires count < DEPTH, so a RAM read and write never target the same address in the same cycle.
- Latency: wput accepted in cycle 0 -> fetch in cycle 1 -> landing in cycle 2 -> empty = 0 and dout valid in cycle 3.
- Sustained drain rate: 1 word per 2 cycles. Sustained fill rate: 1 word per cycle.
- Pulses: overflow = wput & full and underflow = rget & empty, both registered and high for exactly 1 cycle per offending request.
- count increments on push, decrements on pop, and is unchanged when both occur. Range 0..DEPTH.

Test Plan:
- Reset, then idle -> empty = 1, full = 0, count = 0, dout = 0, ram_wen = 0.
- Push 8'hA5 in cycle 0 (DEPTH = 8) -> ram_wen = 1 with ram_waddr = 0 in cycle 0; ram_raddr = 0 with a fetch in cycle 1; empty = 0 and dout = 8'hA5 in cycle 3; count = 1 from cycle 1.
- Push 8 words 1..8 back to back, then hold wput = 1 with din = 9 -> full = 1 after the 8th write; overflow pulses; word 9 is never written; count = 8.
- Drain the full FIFO with rget held high -> dout sequence 1..8 at one word per 2 cycles; pointers wrap to 0; the extra rget after the last word gives an underflow pulse and empty = 1.
- Run 20 words with concurrent wput and rget at random duty -> output order matches input order exactly; ram_raddr never equals ram_waddr while ram_wen = 1 and a fetch is issued.
- Assert rst_n low with 5 words queued and a fetch pending -> outputs return to reset values immediately; a subsequent push of 8'h3C emerges as the first dout.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external 1-cycle-latency
// simple dual-port RAM; the head word is held in a registered output stage.
module ram_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wput,
    output logic                     full,
    output logic                     overflow,
    output logic [WIDTH-1:0]         dout,
    input  logic                     rget,
    output logic                     empty,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] ram_waddr,
    output logic [WIDTH-1:0]         ram_wdata,
    output logic                     ram_wen,
    output logic [$clog2(DEPTH)-1:0] ram_raddr,
    input  logic [WIDTH-1:0]         ram_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_ram_cnt;
    logic             r_fetch_pending;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_dout;
    logic             r_overflow;
    logic             r_underflow;

    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_hold;
    logic             w_fetch;

    assign w_count = r_ram_cnt + CW'(r_fetch_pending) + CW'(r_out_valid);
    assign w_full  = (w_count == CW'(DEPTH));
    assign w_push  = wput & ~w_full;
    assign w_pop   = rget & r_out_valid;
    // Output stage stays occupied if the head survives this edge; only then is a fetch blocked.
    assign w_hold  = r_out_valid & ~w_pop;
    assign w_fetch = (r_ram_cnt != '0) & ~w_hold & ~r_fetch_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_ram_cnt       <= '0;
            r_fetch_pending <= 1'b0;
            r_out_valid     <= 1'b0;
            r_dout          <= '0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_fetch)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_ram_cnt       <= r_ram_cnt + CW'(w_push) - CW'(w_fetch);
            r_fetch_pending <= w_fetch;
            if (r_fetch_pending) begin
                r_dout      <= ram_rdata;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_overflow  <= wput & w_full;
            r_underflow <= rget & ~r_out_valid;
        end
    end

    assign full      = w_full;
    assign empty     = ~r_out_valid;
    assign count     = w_count;
    assign dout      = r_dout;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign ram_waddr = r_wr_ptr;
    assign ram_wdata = din;
    assign ram_wen   = w_push;
    assign ram_raddr = r_rd_ptr;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl with a behavioural RAM and a queue-based
// reference model of the FIFO's occupancy, head visibility and data order.
module tb_ram_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             wput = 1'b0;
    logic             rget = 1'b0;
    logic             full, overflow, empty, underflow, ram_wen;
    logic [WIDTH-1:0] dout, ram_wdata;
    logic [WIDTH-1:0] ram_rdata = '0;
    logic [AW:0]      count;
    logic [AW-1:0]    ram_waddr, ram_raddr;

    logic [WIDTH-1:0] mem [DEPTH];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: every word held, in arrival order.
    logic [WIDTH-1:0] q [$];
    bit               m_vis, m_pend, m_ovf, m_unf;
    logic [WIDTH-1:0] m_dout;
    int               m_wa, m_ra, n_in;

    ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wput(wput), .full(full),
        .overflow(overflow), .dout(dout), .rget(rget), .empty(empty),
        .underflow(underflow), .count(count), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vis = 0; m_pend = 0; m_ovf = 0; m_unf = 0;
        m_dout = '0; m_wa = 0; m_ra = 0;
    endtask

    task automatic check_outputs(input bit w, input logic [WIDTH-1:0] d);
        int sz;
        sz = q.size();
        chk_eq("count", 32'(count), 32'(sz));
        chk_eq("full", 32'(full), 32'(sz == DEPTH));
        chk_eq("empty", 32'(empty), 32'(!m_vis));
        chk_eq("dout", 32'(dout), 32'(m_dout));
        chk_eq("overflow", 32'(overflow), 32'(m_ovf));
        chk_eq("underflow", 32'(underflow), 32'(m_unf));
        chk_eq("ram_wen", 32'(ram_wen), 32'(w && sz < DEPTH));
        chk_eq("ram_wdata", 32'(ram_wdata), 32'(d));
        chk_eq("ram_waddr", 32'(ram_waddr), 32'(m_wa));
        chk_eq("ram_raddr", 32'(ram_raddr), 32'(m_ra));
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d);
        bit push, pop, fetch;
        int in_ram;
        @(negedge clk);
        wput = w; rget = r; din = d;
        #1;
        check_outputs(w, d);
        push   = w && (q.size() < DEPTH);
        pop    = r && m_vis;
        in_ram = q.size() - int'(m_vis) - int'(m_pend);
        fetch  = (in_ram > 0) && !(m_vis && !pop) && !m_pend;
        if (push && fetch)
            chk_eq("addr_collision", 32'(ram_raddr == ram_waddr), 32'(0));
        @(posedge clk);
        m_ovf = w && (q.size() == DEPTH);
        m_unf = r && !m_vis;
        if (pop) void'(q.pop_front());
        if (m_pend) begin
            m_dout = q[0];
            m_vis  = 1;
        end else if (pop) begin
            m_vis = 0;
        end
        m_pend = fetch;
        if (push) begin
            q.push_back(d);
            m_wa = (m_wa + 1) % DEPTH;
            n_in++;
        end
        if (fetch) m_ra = (m_ra + 1) % DEPTH;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wput = 0; rget = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_eq("rst_empty", 32'(empty), 32'(1));
        chk_eq("rst_full", 32'(full), 32'(0));
        chk_eq("rst_count", 32'(count), 32'(0));
        chk_eq("rst_dout", 32'(dout), 32'(0));
        chk_eq("rst_ovf", 32'(overflow), 32'(0));
        chk_eq("rst_unf", 32'(underflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        model_reset();
        n_in = 0;

        do_reset();
        repeat (3) cycle(0, 0, 8'h00);

        // Single word latency
        cycle(1, 0, 8'hA5);
        repeat (3) cycle(0, 0, 8'h00);
        chk_eq("a5_visible", 32'(dout), 32'hA5);
        chk_eq("a5_empty", 32'(empty), 32'(0));
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);

        // Fill to full, then keep pushing word 9
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, 0, 8'(i));
        repeat (3) cycle(1, 0, 8'h09);
        chk_eq("fill_count", 32'(count), 32'(8));
        chk_eq("fill_full", 32'(full), 32'(1));

        // Drain with rget held, plus trailing underflow requests
        for (int i = 0; i < 20; i++) cycle(0, 1, 8'h00);
        chk_eq("drain_empty", 32'(empty), 32'(1));
        chk_eq("drain_last", 32'(dout), 32'h08);
        chk_eq("drain_raddr", 32'(ram_raddr), 32'(0));
        cycle(0, 0, 8'h00);

        // Random concurrent traffic, 20 words
        n_in  = 0;
        guard = 0;
        while (!(n_in >= 20 && q.size() == 0 && !m_pend) && guard < 600) begin
            cycle((n_in < 20) && ($urandom_range(0, 99) < 60),
                  $urandom_range(0, 99) < 55, 8'($urandom));
            guard++;
        end
        chk_eq("rand_done", 32'(guard < 600), 32'(1));
        repeat (2) cycle(0, 1, 8'h00);

        // Reset with words queued and a fetch in flight
        for (int i = 0; i < 6; i++) cycle(1, 0, 8'(8'h50 + i));
        cycle(0, 1, 8'h00);
        chk_eq("pre_rst_pending", 32'(m_pend), 32'(1));
        do_reset();
        cycle(1, 0, 8'h3C);
        repeat (3) cycle(0, 0, 8'h00);
        chk_eq("post_rst_head", 32'(dout), 32'h3C);
        cycle(0, 1, 8'h00);
        repeat (3) cycle(0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
